// File: rtl/rtype_sequencer_pkg.sv
// Shared definitions for the R-type sequencer: opcode/funct codes,
// FSM state encoding and the latched instruction fields.
package rtype_sequencer_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'h00;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    // Instruction fields the sequencer actually uses (shamt is dropped).
    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [5:0] funct;
    } rinstr_t;

    function automatic rinstr_t unpack_instr(input logic [31:0] word);
        rinstr_t f;
        f.op    = word[31:26];
        f.rs    = word[25:21];
        f.rt    = word[20:16];
        f.rd    = word[15:11];
        f.funct = word[5:0];
        return f;
    endfunction

endpackage

// File: rtl/rtype_sequencer_if.sv
// Instruction handshake plus register-file read/write bus of the sequencer.
// master = instruction source / register file side, slave = sequencer.
interface rtype_sequencer_if #(parameter int DATA_W = 32);
    logic [31:0]       Instr;
    logic              InstrValid;
    logic              InstrReady;
    logic [4:0]        RA1;
    logic [4:0]        RA2;
    logic [DATA_W-1:0] DR1;
    logic [DATA_W-1:0] DR2;
    logic [4:0]        AW;
    logic [DATA_W-1:0] Di;
    logic              RegWrite;
    logic              Done;
    logic              Error;

    modport master (
        output Instr, InstrValid, DR1, DR2,
        input  InstrReady, RA1, RA2, AW, Di, RegWrite, Done, Error
    );

    modport slave (
        input  Instr, InstrValid, DR1, DR2,
        output InstrReady, RA1, RA2, AW, Di, RegWrite, Done, Error
    );
endinterface

// File: rtl/rtype_sequencer_alu_r.sv
// Combinational R-type ALU. Valid flags a supported funct code.
module alu_r
    import rtype_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [5:0]        funct,
    output logic [DATA_W-1:0] Result,
    output logic              Valid
);

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;

    assign a_s = A;
    assign b_s = B;

    // Select the operation; add/sub simply wrap, no overflow detection.
    always_comb begin
        Result = '0;
        Valid  = 1'b1;
        case (funct)
            FUNCT_ADD, FUNCT_ADDU: Result = A + B;
            FUNCT_SUB, FUNCT_SUBU: Result = A - B;
            FUNCT_AND:             Result = A & B;
            FUNCT_OR:              Result = A | B;
            FUNCT_NOR:             Result = ~(A | B);
            FUNCT_SLT:             Result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            FUNCT_SLTU:            Result = {{(DATA_W-1){1'b0}}, (A < B)};
            default:               Valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/rtype_sequencer.sv
// Five-state R-type sequencer: IDLE -> READ -> EXEC -> WRITE -> HOLD.
// The register-file addresses are presented from the accept edge so read
// data is available throughout READ; the result, AW and Di are registered
// on leaving READ so they are already stable during EXEC, i.e. one cycle
// before RegWrite rises. Rejected instructions and writes to $0 still walk
// through WRITE (with RegWrite suppressed) so Done timing is uniform.
module rtype_sequencer
    import rtype_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input logic               clk,
    input logic               rst,
    rtype_sequencer_if.slave  bus
);

    logic [2:0]        state;
    rinstr_t           instr_q;
    rinstr_t           instr_in;
    logic              instr_ready;
    logic [4:0]        ra1;
    logic [4:0]        ra2;
    logic [4:0]        aw;
    logic [DATA_W-1:0] alu_out;
    logic              reg_write;
    logic              done;
    logic              error;
    logic              err_pend;
    logic              wr_pend;
    logic [DATA_W-1:0] alu_res;
    logic              alu_vld;
    logic              op_ok;
    logic              unused_shamt;

    assign instr_in     = unpack_instr(bus.Instr);
    assign unused_shamt = ^bus.Instr[10:6];

    alu_r #(.DATA_W(DATA_W)) u_alu (
        .A      (bus.DR1),
        .B      (bus.DR2),
        .funct  (instr_q.funct),
        .Result (alu_res),
        .Valid  (alu_vld)
    );

    assign op_ok = (instr_q.op == OP_RTYPE) && alu_vld;

    // Sequencer state and every registered output; pulses default low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            instr_q     <= '0;
            instr_ready <= 1'b1;
            ra1         <= '0;
            ra2         <= '0;
            aw          <= '0;
            alu_out     <= '0;
            reg_write   <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_pend    <= 1'b0;
            wr_pend     <= 1'b0;
        end else begin
            reg_write <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.InstrValid && instr_ready) begin
                        instr_q     <= instr_in;
                        ra1         <= instr_in.rs;
                        ra2         <= instr_in.rt;
                        instr_ready <= 1'b0;
                        state       <= ST_READ;
                    end
                end
                ST_READ: begin
                    err_pend <= !op_ok;
                    wr_pend  <= op_ok && (instr_q.rd != 5'd0);
                    if (op_ok && (instr_q.rd != 5'd0)) begin
                        aw      <= instr_q.rd;
                        alu_out <= alu_res;
                    end
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    reg_write <= wr_pend;
                    state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    done  <= 1'b1;
                    error <= err_pend;
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.InstrReady = instr_ready;
    assign bus.RA1        = ra1;
    assign bus.RA2        = ra2;
    assign bus.AW         = aw;
    assign bus.Di         = alu_out;
    assign bus.RegWrite   = reg_write;
    assign bus.Done       = done;
    assign bus.Error      = error;

endmodule

// File: tb/tb_rtype_sequencer.sv
// Bench for rtype_sequencer: register-file model, cycle-timeline reference
// model, directed scenarios with literal expectations, randomized traffic.
module tb_rtype_sequencer;

    logic clk;
    logic rst;
    rtype_sequencer_if #(.DATA_W(32)) bus ();

    rtype_sequencer #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file seen by the DUT
    logic [31:0] regs [32];
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;

    assign bus.DR1 = regs[bus.RA1];
    assign bus.DR2 = regs[bus.RA2];

    always @(posedge clk) begin
        if (bus.RegWrite) regs[bus.AW] <= bus.Di;
        else if (ld_en)   regs[ld_addr] <= ld_data;
    end

    // reference ALU: {ok, result}
    function automatic logic [32:0] model_alu(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        case (fn)
            6'h20, 6'h21: return {1'b1, a + b};
            6'h22, 6'h23: return {1'b1, a - b};
            6'h24:        return {1'b1, a & b};
            6'h25:        return {1'b1, a | b};
            6'h27:        return {1'b1, ~(a | b)};
            6'h2A:        return {1'b1, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
            6'h2B:        return {1'b1, (a < b) ? 32'd1 : 32'd0};
            default:      return {1'b0, 32'd0};
        endcase
    endfunction

    // timeline model: age = cycles since acceptance (0 = idle)
    int          age = 0;
    logic        m_wr = 1'b0;
    logic        m_err = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_res = '0;
    logic [4:0]  e_ra1 = '0;
    logic [4:0]  e_ra2 = '0;
    logic [4:0]  e_aw = '0;
    logic [31:0] e_di = '0;
    logic [31:0] mregs [32];

    always @(posedge clk) begin
        logic [32:0] r;
        if (age == 3 && m_wr) mregs[m_rd] = m_res;
        if (ld_en) mregs[ld_addr] = ld_data;
        if (rst) begin
            age = 0; m_wr = 1'b0; m_err = 1'b0;
            e_ra1 = '0; e_ra2 = '0; e_aw = '0; e_di = '0;
        end else if (age == 0) begin
            if (bus.InstrValid) begin
                e_ra1 = bus.Instr[25:21];
                e_ra2 = bus.Instr[20:16];
                m_rd  = bus.Instr[15:11];
                r     = model_alu(bus.Instr[5:0], mregs[e_ra1], mregs[e_ra2]);
                m_err = (bus.Instr[31:26] != 6'h00) || !r[32];
                m_res = r[31:0];
                m_wr  = !m_err && (m_rd != 5'd0);
                age   = 1;
            end
        end else begin
            age = (age == 4) ? 0 : age + 1;
            if (age == 2 && m_wr) begin
                e_aw = m_rd;
                e_di = m_res;
            end
        end
    end

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // sample at the falling edge and compare every output with the model
    task automatic sample();
        @(negedge clk);
        if (chk_en) begin
            chk("mdl InstrReady", 32'(bus.InstrReady), 32'(age == 0));
            chk("mdl RA1", 32'(bus.RA1), 32'(e_ra1));
            chk("mdl RA2", 32'(bus.RA2), 32'(e_ra2));
            chk("mdl AW", 32'(bus.AW), 32'(e_aw));
            chk("mdl Di", bus.Di, e_di);
            chk("mdl RegWrite", 32'(bus.RegWrite), 32'(age == 3 && m_wr));
            chk("mdl Done", 32'(bus.Done), 32'(age == 4));
            chk("mdl Error", 32'(bus.Error), 32'(age == 4 && m_err));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        sample(); advance();
        ld_en = 1'b0;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
        return {op, rs, rt, rd, 5'd0, fn};
    endfunction

    // issue one instruction from IDLE and check its five cycles literally
    task automatic directed(input string nm, input logic [31:0] ins, input logic [4:0] aw,
                            input logic [31:0] di, input logic wr, input logic err);
        bus.InstrValid = 1'b1; bus.Instr = ins;
        sample(); chk({nm, " ready@N"}, 32'(bus.InstrReady), 32'd1); advance();
        bus.InstrValid = 1'b0; bus.Instr = $urandom;
        sample();
        chk({nm, " RA1"}, 32'(bus.RA1), 32'(ins[25:21]));
        chk({nm, " RA2"}, 32'(bus.RA2), 32'(ins[20:16]));
        chk({nm, " ready@N+1"}, 32'(bus.InstrReady), 32'd0);
        advance();
        bus.Instr = $urandom;
        sample(); advance();
        sample();
        chk({nm, " RegWrite@N+3"}, 32'(bus.RegWrite), 32'(wr));
        chk({nm, " AW@N+3"}, 32'(bus.AW), 32'(aw));
        chk({nm, " Di@N+3"}, bus.Di, di);
        advance();
        sample();
        chk({nm, " Done@N+4"}, 32'(bus.Done), 32'd1);
        chk({nm, " Error@N+4"}, 32'(bus.Error), 32'(err));
        chk({nm, " RegWrite@N+4"}, 32'(bus.RegWrite), 32'd0);
        advance();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rd;
        case ($urandom_range(0, 9))
            0: fn = 6'h20;  1: fn = 6'h21;  2: fn = 6'h22;
            3: fn = 6'h23;  4: fn = 6'h24;  5: fn = 6'h25;
            6: fn = 6'h27;  7: fn = 6'h2A;  8: fn = 6'h2B;
            default: fn = 6'($urandom_range(0, 63));
        endcase
        op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
        rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        return {op, 5'($urandom), 5'($urandom), rd, 5'($urandom), fn};
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    int acc_first;
    int acc_second;
    int done_at;

    initial begin
        rst = 1'b1; bus.InstrValid = 1'b0; bus.Instr = 32'h0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        advance(); advance();
        rst = 1'b0;
        sample();
        chk("reset InstrReady", 32'(bus.InstrReady), 32'd1);
        chk("reset RA1", 32'(bus.RA1), 32'd0);
        chk("reset AW", 32'(bus.AW), 32'd0);
        chk("reset Di", bus.Di, 32'd0);
        chk("reset RegWrite", 32'(bus.RegWrite), 32'd0);
        chk("reset Done", 32'(bus.Done), 32'd0);
        chk("reset Error", 32'(bus.Error), 32'd0);
        advance();
        chk_en = 1'b1;

        // pin the reference ALU itself
        chk("model add wrap", model_alu(6'h20, 32'hFFFF_FFFF, 32'd1), {1'b1, 32'd0});
        chk("model sub", model_alu(6'h22, 32'd5, 32'd9), {1'b1, 32'hFFFF_FFFC});
        chk("model slt neg", model_alu(6'h2A, 32'hFFFF_FFFF, 32'd9), {1'b1, 32'd1});
        chk("model sltu big", model_alu(6'h2B, 32'hFFFF_FFFF, 32'd9), {1'b1, 32'd0});

        load(5'd1, 32'd25); load(5'd2, 32'd10); load(5'd3, 32'd5);
        load(5'd4, 32'd9);  load(5'd5, 32'hFFFF_FFFF); load(5'd6, 32'd1);

        directed("add", mk(6'h00, 5'd1, 5'd2, 5'd21, 6'h20), 5'd21, 32'd35, 1'b1, 1'b0);
        chk("add RA1 literal", 32'(bus.RA1), 32'd1);
        chk("add RA2 literal", 32'(bus.RA2), 32'd2);
        directed("sub", mk(6'h00, 5'd3, 5'd4, 5'd22, 6'h22), 5'd22, 32'hFFFF_FFFC, 1'b1, 1'b0);
        directed("slt", mk(6'h00, 5'd3, 5'd4, 5'd23, 6'h2A), 5'd23, 32'd1, 1'b1, 1'b0);
        directed("lw", mk(6'h23, 5'd1, 5'd2, 5'd8, 6'h20), 5'd23, 32'd1, 1'b0, 1'b1);
        directed("add wrap", mk(6'h00, 5'd5, 5'd6, 5'd7, 6'h20), 5'd7, 32'd0, 1'b1, 1'b0);
        load(5'd3, 32'hFFFF_FFFF);
        directed("sltu", mk(6'h00, 5'd3, 5'd4, 5'd24, 6'h2B), 5'd24, 32'd0, 1'b1, 1'b0);
        directed("add r10", mk(6'h00, 5'd1, 5'd2, 5'd10, 6'h20), 5'd10, 32'd35, 1'b1, 1'b0);
        directed("funct0", mk(6'h00, 5'd1, 5'd2, 5'd9, 6'h00), 5'd10, 32'd35, 1'b0, 1'b1);
        directed("rd0", mk(6'h00, 5'd1, 5'd2, 5'd0, 6'h20), 5'd10, 32'd35, 1'b0, 1'b0);

        // reset asserted while in WRITE
        bus.InstrValid = 1'b1; bus.Instr = mk(6'h00, 5'd1, 5'd2, 5'd11, 6'h20);
        sample(); advance();
        bus.InstrValid = 1'b0;
        sample(); advance();
        sample(); advance();
        rst = 1'b1;
        sample(); chk("rstW RegWrite in WRITE", 32'(bus.RegWrite), 32'd1); advance();
        rst = 1'b0;
        sample();
        chk("rstW RegWrite", 32'(bus.RegWrite), 32'd0);
        chk("rstW Done", 32'(bus.Done), 32'd0);
        chk("rstW InstrReady", 32'(bus.InstrReady), 32'd1);
        chk("rstW AW", 32'(bus.AW), 32'd0);
        chk("rstW Di", bus.Di, 32'd0);
        advance();

        // InstrValid held high: accepts five cycles apart
        acc_first = -1; acc_second = -1; done_at = -1;
        bus.InstrValid = 1'b1; bus.Instr = mk(6'h00, 5'd1, 5'd2, 5'd12, 6'h25);
        for (int i = 0; i < 11; i++) begin
            sample();
            if (bus.InstrReady) begin
                if (acc_first < 0) acc_first = i;
                else if (acc_second < 0) acc_second = i;
            end
            if (bus.Done && done_at < 0) done_at = i;
            advance();
        end
        bus.InstrValid = 1'b0;
        chk("b2b first accept", 32'(acc_first), 32'd0);
        chk("b2b second accept", 32'(acc_second), 32'd5);
        chk("b2b Done", 32'(done_at), 32'd4);
        for (int i = 0; i < 6; i++) begin sample(); advance(); end

        // randomized traffic
        for (int i = 0; i < 32; i++) load(5'(i), rand_val());
        for (int i = 0; i < 700; i++) begin
            bus.InstrValid = ($urandom_range(0, 2) != 0);
            bus.Instr = rand_instr();
            rst = ($urandom_range(0, 79) == 0);
            sample(); advance();
        end
        rst = 1'b0; bus.InstrValid = 1'b0;
        for (int i = 0; i < 7; i++) begin sample(); advance(); end
        for (int i = 0; i < 32; i++) chk($sformatf("regfile r%0d", i), regs[i], mregs[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtype_sequencer.md
RTYPE_SEQUENCER -- requirements
Module: rtype_sequencer

Interface
REQ-001 SHALL have parameter: DATA_W, 32, datapath width (only 32 supported).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: Instr  input  32  R-type instruction word (op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0]).
REQ-005 SHALL have port: InstrValid  input  1  Instr is offered.
REQ-006 SHALL have port: InstrReady  output  1  sequencer can accept Instr.
REQ-007 SHALL have port: RA1  output  5  register-file read address 1 (rs).
REQ-008 SHALL have port: RA2  output  5  register-file read address 2 (rt).
REQ-009 SHALL have port: DR1  input  32  register-file read data 1 (combinational read).
REQ-010 SHALL have port: DR2  input  32  register-file read data 2 (combinational read).
REQ-011 SHALL have port: AW  output  5  register-file write address (rd).
REQ-012 SHALL have port: Di  output  32  register-file write data.
REQ-013 SHALL have port: RegWrite  output  1  register-file write enable (level-sensitive at the register file).
REQ-014 SHALL have port: Done  output  1  one-cycle pulse, instruction retired.
REQ-015 SHALL have port: Error  output  1  one-cycle pulse with Done, instruction rejected.

Function
REQ-016 SHALL implement FSM states IDLE, READ, EXEC, WRITE, HOLD; all outputs registered.
REQ-017 IDLE: InstrReady=1; on InstrValid&InstrReady latch Instr, go READ; otherwise stay.
REQ-018 READ: RA1=rs, RA2=rt driven from latched Instr; go EXEC next cycle.
REQ-019 EXEC: compute result from DR1/DR2, register into ALUOut, go WRITE; if op!=0 or funct unsupported go HOLD with Error pending.
REQ-020 WRITE: AW=rd, Di=ALUOut, RegWrite=1 for exactly one cycle; go HOLD.
REQ-021 HOLD: RegWrite=0, AW/Di unchanged from WRITE, Done=1 (Error=1 if pending); go IDLE.
REQ-022 AW and Di SHALL be stable from the cycle before RegWrite rises until the cycle after it falls.
REQ-023 Latency: acceptance at cycle N -> RegWrite high at N+3, Done at N+4; throughput one instruction per 5 cycles.
REQ-024 InstrReady SHALL be 0 in all states except IDLE; Instr changes outside IDLE are ignored.
REQ-025 Supported funct: 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed), 0x2B sltu.
REQ-026 Add/sub SHALL wrap modulo 2^32; no overflow trap; slt/sltu produce 32'd0 or 32'd1.
REQ-027 rd==0: no RegWrite pulse, Done=1, Error=0 (write to $0 suppressed).
REQ-028 Error path: RegWrite never asserted, AW/Di hold previous values.

Reset
REQ-029 On rst at a rising edge: state=IDLE, InstrReady=1, RA1=RA2=AW=0, Di=0, RegWrite=0, Done=0, Error=0, latched Instr=0.
REQ-030 rst mid-operation (any state) SHALL abort the instruction; RegWrite low from that edge, no Done.
REQ-031 rst takes priority over InstrValid on the same edge.

Structure
REQ-032 Shared package SHALL hold funct constants, opcode R-type constant (6'h00), and FSM state encoding.
REQ-033 ALU SHALL be a combinational sub-module alu_r (A, B, funct -> Result, Valid).
REQ-034 Estimated size 150-250 lines RTL including alu_r.

Verification
REQ-035 Reg1=25, Reg2=10, Instr add rd=21 -> RA1=1, RA2=2, AW=21, Di=35, RegWrite at N+3, Done at N+4.
REQ-036 Reg3=5, Reg4=9, sub rd=22 -> Di=32'hFFFFFFFC; slt same operands rd=23 -> Di=1; sltu with Reg3=-1 -> Di=0.
REQ-037 Reg5=32'hFFFFFFFF, Reg6=1, add rd=7 -> Di=0 (wrap), no Error.
REQ-038 op=6'h23 (lw) or funct=0x00 -> no RegWrite, Done=1, Error=1 at N+4.
REQ-039 add with rd=0 -> RegWrite stays 0, Done=1, Error=0.
REQ-040 rst asserted in WRITE -> RegWrite 0 next cycle, no Done, InstrReady=1; back-to-back InstrValid held high -> second accept at N+5.
